// File: rtl/demux_14_stage.sv
// Registered 1-to-4 valid/ready demultiplexer with a one-entry holding register
// and per-lane delivered-beat counters.
module demux_14_stage #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_sel,
  input  logic [WIDTH-1:0]   in_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [4*CNT_W-1:0] beat_cnt
);

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  logic               full_q, full_d;
  logic [1:0]         sel_q, sel_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [4*CNT_W-1:0] cnt_q, cnt_d;
  logic               drain;
  logic               accept;

  // Draining the held beat frees the slot in the same cycle, so a new beat can
  // be taken back-to-back; this makes in_ready depend combinationally on out_ready.
  always_comb begin
    drain    = (full_q == FULL) && out_ready[sel_q];
    in_ready = (full_q == EMPTY) || drain;
    accept   = in_valid && in_ready;

    full_d = full_q;
    sel_d  = sel_q;
    data_d = data_q;
    if (accept) begin
      full_d = FULL;
      sel_d  = in_sel;
      data_d = in_data;
    end else if (drain) begin
      full_d = EMPTY;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (drain && (sel_q == 2'(i))) begin
        cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    out_valid = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      out_valid[i] = (full_q == FULL) && (sel_q == 2'(i));
    end
    out_data = data_q;
    beat_cnt = cnt_q;
  end

  // A beat still held when reset arrives is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= EMPTY;
      sel_q  <= 2'd0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      sel_q  <= sel_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
